// File: rtl/system_pkg.sv
// ---------------------------------------------------------------------------
// system_pkg
// Shared constants and types for the compute-RAM system and its loader.
//   BRAM_AWIDTH / BRAM_DWIDTH / BRAM_DEPTH : BRAM geometry
//   COMPUTE_DWIDTH                         : operand width
//   loader_state_t                         : system_loader FSM states
//   pack_word()                            : packs an operand pair into a BRAM word
// ---------------------------------------------------------------------------
package system_pkg;

  localparam int BRAM_AWIDTH    = 9;
  localparam int BRAM_DWIDTH    = 40;
  localparam int BRAM_DEPTH     = 1 << BRAM_AWIDTH;
  localparam int COMPUTE_DWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } loader_state_t;

  // Word layout: {zero padding, input2, input1}; padding bits are always 0.
  function automatic logic [BRAM_DWIDTH-1:0] pack_word(
    input logic [COMPUTE_DWIDTH-1:0] input1,
    input logic [COMPUTE_DWIDTH-1:0] input2
  );
    return {{(BRAM_DWIDTH - 2*COMPUTE_DWIDTH){1'b0}}, input2, input1};
  endfunction

endpackage

// File: rtl/system_loader.sv
// ---------------------------------------------------------------------------
// system_loader
// Upstream sequencer for the compute-RAM system. Accepts a valid/ready stream
// of operand pairs, writes them as packed BRAM words through the system's
// external port-b path, then holds start until the system pulses done (or a
// run timeout expires).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for go; stream not ready, system owns its BRAM
// LOAD   | accepting pairs and writing them over external port b
// RUN    | start held high, timeout timer counting down
// FINISH | start dropped; complete pulses if the run ended on done
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   go                      : one-cycle load+run request (IDLE only)
//   load_start_addr         : first BRAM address, sampled on accepted go
//   num_words               : pairs to load (0 means BRAM_DEPTH), sampled on go
//   in_valid/in_ready/in_data : operand-pair stream, in_data = {input2, input1}
//   external, bram_sel      : port-b ownership/select towards the system
//   bram_addr_ext/_wdata_ext/_wren_ext : registered external write port
//   start                   : level run request to the system
//   done                    : one-cycle completion pulse from the system
//   busy                    : FSM not in IDLE
//   complete                : one-cycle pulse after a run ended on done
//   timeout_err             : sticky, cleared by reset or the next accepted go
// ---------------------------------------------------------------------------
module system_loader #(
  parameter int BRAM_AWIDTH    = 9,
  parameter int BRAM_DWIDTH    = 40,
  parameter int COMPUTE_DWIDTH = 8,
  parameter int TIMEOUT        = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        go,
  input  logic [BRAM_AWIDTH-1:0]      load_start_addr,
  input  logic [BRAM_AWIDTH:0]        num_words,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*COMPUTE_DWIDTH-1:0] in_data,
  output logic                        external,
  output logic                        bram_sel,
  output logic [BRAM_AWIDTH-1:0]      bram_addr_ext,
  output logic [BRAM_DWIDTH-1:0]      bram_wdata_ext,
  output logic                        bram_wren_ext,
  output logic                        start,
  input  logic                        done,
  output logic                        busy,
  output logic                        complete,
  output logic                        timeout_err
);

  import system_pkg::*;

  // Run timer is a down-counter loaded with TIMEOUT-1 while loading; reaching
  // zero in RUN means TIMEOUT run cycles have elapsed.
  localparam int                 TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]      TIMER_LOAD = TW'(TIMEOUT - 1);
  localparam logic [BRAM_AWIDTH:0] FULL_COUNT = {1'b1, {BRAM_AWIDTH{1'b0}}};

  loader_state_t state_q, state_d;

  logic [BRAM_AWIDTH-1:0] addr_q;
  logic [BRAM_AWIDTH:0]   count_q;
  logic [BRAM_AWIDTH:0]   target_q;
  logic [TW-1:0]          timer_q;
  logic                   handshake;
  logic                   load_done;
  logic                   timer_expired;

  assign load_done     = (count_q == target_q);
  assign handshake     = in_valid & in_ready;
  // done takes priority if it coincides with the final timer cycle.
  assign timer_expired = (state_q == RUN) && !done && (timer_q == '0);

  assign busy     = (state_q != IDLE);
  assign bram_sel = 1'b0;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    external = 1'b0;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) state_d = LOAD;
      end
      LOAD: begin
        external = 1'b1;
        // Ready drops once the last pair is in; the FSM stays in LOAD one more
        // cycle so the final registered write completes while we still own
        // port b.
        in_ready = !load_done;
        if (load_done) state_d = RUN;
      end
      RUN: begin
        start = 1'b1;
        if (done || timer_expired) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      count_q        <= '0;
      target_q       <= '0;
      timer_q        <= '0;
      bram_addr_ext  <= '0;
      bram_wdata_ext <= '0;
      bram_wren_ext  <= 1'b0;
      complete       <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bram_wren_ext <= handshake;
      complete      <= (state_q == RUN) && done;

      if (handshake) begin
        bram_addr_ext  <= addr_q;
        bram_wdata_ext <= pack_word(in_data[COMPUTE_DWIDTH-1:0],
                                    in_data[2*COMPUTE_DWIDTH-1:COMPUTE_DWIDTH]);
        addr_q         <= addr_q + 1'b1;
        count_q        <= count_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (go) begin
            addr_q      <= load_start_addr;
            target_q    <= (num_words == '0) ? FULL_COUNT : num_words;
            count_q     <= '0;
            timeout_err <= 1'b0;
          end
        end
        LOAD: begin
          timer_q <= TIMER_LOAD;
        end
        RUN: begin
          timer_q <= timer_q - 1'b1;
          if (timer_expired) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_system_loader.sv
module tb_system_loader;

  localparam int AW = 9;
  localparam int DW = 40;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic [AW-1:0] load_start_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*CW-1:0] in_data = '0;
  logic          external;
  logic          bram_sel;
  logic [AW-1:0] bram_addr_ext;
  logic [DW-1:0] bram_wdata_ext;
  logic          bram_wren_ext;
  logic          start;
  logic          done = 1'b0;
  logic          busy;
  logic          complete;
  logic          timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  logic [AW-1:0] mon_addr = '0;
  logic [AW+DW-1:0] sb[$];

  system_loader #(
    .BRAM_AWIDTH(AW), .BRAM_DWIDTH(DW), .COMPUTE_DWIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .load_start_addr(load_start_addr),
    .num_words(num_words), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .external(external), .bram_sel(bram_sel),
    .bram_addr_ext(bram_addr_ext), .bram_wdata_ext(bram_wdata_ext),
    .bram_wren_ext(bram_wren_ext), .start(start), .done(done), .busy(busy),
    .complete(complete), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: a handshake seen before an edge pushes the expected write;
  // every write cycle pops and compares. Pops happen before pushes.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (bram_wren_ext) begin
      vectors++;
      wr_count++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL wren_unexpected: write at addr %0d with no pending handshake", bram_addr_ext);
      end else begin
        e = sb.pop_front();
        if ({external, bram_sel, bram_addr_ext, bram_wdata_ext} !== {1'b1, 1'b0, e}) begin
          miscompares++;
          $display("FAIL write: got ext=%b sel=%b addr=%0d data=%h, want ext=1 sel=0 addr=%0d data=%h",
                   external, bram_sel, bram_addr_ext, bram_wdata_ext, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (!reset && in_valid && in_ready) begin
      sb.push_back({mon_addr, {{(DW-2*CW){1'b0}}, in_data}});
      mon_addr = mon_addr + 1'b1;
    end
  end

  task automatic do_go(input logic [AW-1:0] a, input logic [AW:0] n);
    mon_addr = a;
    wr_count = 0;
    load_start_addr = a;
    num_words = n;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // Streams n pairs; returns one cycle after the last handshake edge.
  task automatic stream(input int n, input int stall_pct, input int mode, input int go_at);
    int i = 0;
    int guard = 0;
    bit hs;
    bit go_sent = 0;
    while (i < n && guard < 5000) begin
      in_valid = ($urandom_range(99) >= stall_pct);
      in_data  = (mode == 0) ? {8'(2*i + 2), 8'(2*i + 1)} : 16'($urandom);
      if (i == go_at && !go_sent) begin
        go = 1'b1;
        load_start_addr = 9'd300;
        num_words = 10'd1;
        go_sent = 1;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      go = 1'b0;
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    vectors++;
    if (i != n) begin
      miscompares++;
      $display("FAIL stream_guard: accepted %0d pairs, want %0d", i, n);
    end
  endtask

  // Final write cycle then first RUN cycle.
  task automatic load_tail();
    vectors++;
    if ({in_ready, start, external, busy} !== 4'b0011) begin
      miscompares++;
      $display("FAIL tail_write_cycle: rdy/start/ext/busy=%b want 0011", {in_ready, start, external, busy});
    end
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, start, external, bram_wren_ext} !== 4'b0100) begin
      miscompares++;
      $display("FAIL run_entry: rdy/start/ext/wren=%b want 0100", {in_ready, start, external, bram_wren_ext});
    end
  endtask

  task automatic run_to_done(input int wait_cycles, input int go_at);
    for (int k = 0; k < wait_cycles; k++) begin
      if (k == go_at) go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      vectors++;
      if (start !== 1'b1) begin
        miscompares++;
        $display("FAIL run_hold: start=%b want 1 at run cycle %0d", start, k + 1);
      end
    end
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    vectors++;
    if ({start, complete, busy, timeout_err} !== 4'b0110) begin
      miscompares++;
      $display("FAIL finish: start/complete/busy/terr=%b want 0110", {start, complete, busy, timeout_err});
    end
    @(posedge clk); #1;
    vectors++;
    if ({busy, complete, start} !== 3'b000) begin
      miscompares++;
      $display("FAIL back_to_idle: busy/complete/start=%b want 000", {busy, complete, start});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, external, bram_sel, bram_addr_ext, bram_wdata_ext, bram_wren_ext,
         start, busy, complete, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b ext=%b sel=%b addr=%0d data=%h wren=%b start=%b busy=%b cmp=%b terr=%b want all 0",
               in_ready, external, bram_sel, bram_addr_ext, bram_wdata_ext, bram_wren_ext,
               start, busy, complete, timeout_err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_go(9'd0, 10'd4);
    vectors++;
    if ({busy, in_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL go_latency: busy/rdy=%b want 11", {busy, in_ready});
    end
    stream(4, 0, 0, -1);
    load_tail();
    run_to_done(3, -1);
    vectors++;
    if (wr_count != 4 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL basic_count: writes=%0d pending=%0d want 4 and 0", wr_count, sb.size());
    end
  endtask

  task automatic test_wrap();
    do_go(9'd510, 10'd3);
    stream(3, 0, 1, -1);
    load_tail();
    run_to_done(1, -1);
    vectors++;
    if (wr_count != 3 || sb.size() != 0 || mon_addr != 9'd1) begin
      miscompares++;
      $display("FAIL wrap_count: writes=%0d pending=%0d want 3 and 0", wr_count, sb.size());
    end
  endtask

  task automatic test_full_random();
    do_go(9'd7, 10'd0);
    stream(512, 40, 1, -1);
    load_tail();
    run_to_done(5, -1);
    vectors++;
    if (wr_count != 512 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL full_count: writes=%0d pending=%0d want 512 and 0", wr_count, sb.size());
    end
  endtask

  task automatic test_go_ignored();
    do_go(9'd20, 10'd6);
    stream(6, 0, 1, 2);
    load_tail();
    run_to_done(6, 2);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (wr_count != 6 || sb.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL go_ignored: writes=%0d pending=%0d busy=%b want 6, 0, 0", wr_count, sb.size(), busy);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    do_go(9'd100, 10'd2);
    stream(2, 0, 1, -1);
    load_tail();
    while (start === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    vectors++;
    if (cnt != TO) begin
      miscompares++;
      $display("FAIL timeout_len: run cycles=%0d want %0d", cnt, TO);
    end
    vectors++;
    if ({start, complete, timeout_err, busy} !== 4'b0011) begin
      miscompares++;
      $display("FAIL timeout_finish: start/complete/terr/busy=%b want 0011", {start, complete, timeout_err, busy});
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, complete, timeout_err} !== 3'b001) begin
      miscompares++;
      $display("FAIL timeout_sticky: busy/complete/terr=%b want 001", {busy, complete, timeout_err});
    end
    do_go(9'd0, 10'd1);
    vectors++;
    if ({busy, timeout_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout_clear: busy/terr=%b want 10", {busy, timeout_err});
    end
    stream(1, 0, 1, -1);
    load_tail();
    run_to_done(15, -1);
  endtask

  task automatic test_reset_mid_load();
    do_go(9'd64, 10'd5);
    stream(2, 0, 1, -1);
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, external, bram_sel, bram_addr_ext, bram_wdata_ext, bram_wren_ext,
         start, busy, complete, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_load: rdy=%b ext=%b addr=%0d data=%h wren=%b start=%b busy=%b want all 0",
               in_ready, external, bram_addr_ext, bram_wdata_ext, bram_wren_ext, start, busy);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (wr_count != 2 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL reset_drop: writes=%0d pending=%0d want 2 and 0", wr_count, sb.size());
    end
    do_go(9'd200, 10'd3);
    stream(3, 20, 1, -1);
    load_tail();
    run_to_done(2, -1);
    vectors++;
    if (wr_count != 3 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL after_reset_run: writes=%0d pending=%0d want 3 and 0", wr_count, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full_random();
    test_go_ignored();
    test_timeout();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
